snake_game_ctrl: RTL
====================

// Module: snake_game_ctrl
// PURPOSE
//  Game sequencer for the snake datapath: owns the game FSM, generates the one-cycle
//  step strobe that advances the body, places food boxes on the 8-px grid via an LFSR,
//  keeps the score and speeds up the step rate as food is eaten. Sits between the
//  button inputs, the snake body datapath (step, clear, box position) and the VGA/score path.
// PARAMETERS
//  STEP_INIT  50_000_000  clk cycles per step after reset/new game (1 Hz at 50 MHz)
//  STEP_MIN    6_250_000  lowest allowed step period, in cycles
//  STEP_DEC    2_500_000  period reduction per box eaten, in cycles
//  SCORE_MAX  99          score saturation value
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  btn_start  in   1   debounced level; rising edge = start / pause / resume / restart
//  eat_req    in   1   one-cycle pulse from body datapath: head hit box
//  collision  in   1   level from body datapath: head hit body
//  head_x     in   10  current head x (px), used to keep the box off the head
//  head_y     in   9   current head y (px)
//  step       out  1   one-cycle strobe: advance snake by one cell
//  snake_clr  out  1   one-cycle strobe: reinitialise body datapath
//  box_valid  out  1   box_x/box_y hold a placed box (draw + compare only when 1)
//  box_x      out  10  box x, multiple of 8, 0..632
//  box_y      out  9   box y, multiple of 8, 0..472
//  score      out  7   boxes eaten this game, saturates at SCORE_MAX
//  game_over  out  1   high while in OVER
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): state=IDLE, step=0, snake_clr=0, box_valid=0,
//    box_x=0, box_y=0, score=0, game_over=0, period=STEP_INIT, step count=0,
//    LFSR=16'hACE1, btn edge register=0. rst mid-game aborts to IDLE identically.
//  - btn_start edge: start_edge = btn_start & ~btn_q; btn_q registered every cycle.
//  - States: IDLE, PLACE, PLAY, PAUSE, OVER.
//    IDLE  --start_edge--> PLACE; snake_clr=1 that cycle; score=0; period=STEP_INIT; count=0.
//    PLACE: box_valid=0; each cycle test candidate; on accept latch box_x/box_y, box_valid=1
//           next cycle, -> PLAY. Step count frozen. start_edge ignored.
//    PLAY  : count increments; when count==period-1, step=1 and count=0. First step
//           exactly `period` cycles after entering PLAY from a new game.
//           collision -> OVER (priority over everything). eat_req -> score+1 (sat),
//           period=max(period-STEP_DEC, STEP_MIN), -> PLACE. start_edge -> PAUSE.
//           Priority in one cycle: collision > eat_req > start_edge. A step due in
//           the same cycle as eat_req/start_edge is still issued.
//    PAUSE : count and box frozen, no step; start_edge -> PLAY; collision ignored.
//    OVER  : game_over=1, no step, box and score held; start_edge -> PLACE with
//           snake_clr=1, score=0, period=STEP_INIT, count=0 (same as from IDLE).
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in every state;
//    never all-zero. Candidate col=lfsr[6:0], row=lfsr[14:9]. Accept iff col<80,
//    row<60 and {col,3'b000},{row,3'b000} != head_x,head_y. box_x={col,3'b000},
//    box_y={row,3'b000}. Rejection retries next cycle; no upper bound on retries.
//  - eat_req outside PLAY is ignored. step and snake_clr are never high together.
//  - Period arithmetic 26-bit unsigned; subtraction saturates at STEP_MIN, no wrap.
// STRUCTURE
//  - Shared package snake_pkg: state encoding (IDLE..OVER, 3-bit), CELL_PX=8,
//    GRID_COLS=80, GRID_ROWS=60, LFSR seed 16'hACE1.
//  - One sub-module: snake_lfsr16 (clk, rst, q[15:0]); rest (FSM, step counter,
//    score/period regs, candidate check) lives in snake_game_ctrl.
// TESTING  (bench overrides STEP_INIT=20, STEP_MIN=8, STEP_DEC=4)
//  1 rst 3 cycles -> all outputs 0, state IDLE; 100 idle cycles -> no step, no snake_clr.
//  2 btn_start 0->1 -> snake_clr pulse 1 cycle, box_valid=1 within bounded cycles,
//    box_x%8==0, box_x<=632, box_y<=472, box != head; steps every 20 cycles.
//  3 eat_req x3 in PLAY -> score=3, step spacing 16,12,8; 4th eat -> spacing stays 8;
//    box_valid drops in PLACE, no step while in PLACE.
//  4 collision and eat_req same cycle -> OVER, game_over=1, score unchanged, no steps;
//    btn_start edge -> snake_clr, score=0, spacing back to 20.
//  5 btn_start edge in PLAY -> PAUSE, no step for 200 cycles; edge again -> next step
//    after remaining count (count preserved), not a full period.
//  6 rst asserted mid-PLAY with step due same cycle -> step=0, all regs at reset values;
//    head forced equal to every candidate for 50 cycles -> box_valid stays 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: FSM encoding and the
// playfield grid (80 x 60 cells of 8 px).
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLACE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int unsigned CELL_PX   = 8;
  localparam int unsigned GRID_COLS = 80;
  localparam int unsigned GRID_ROWS = 60;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/snake_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running in every state.
// The seed is non-zero, so the register can never reach the all-zero lockup state.
module snake_lfsr16
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = {fb, lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: FSM, step-rate timer, LFSR food placement, score and
// speed-up. Every output is registered, so a reset edge clears a pending step.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_INIT = 50_000_000,
  parameter int unsigned STEP_MIN  = 6_250_000,
  parameter int unsigned STEP_DEC  = 2_500_000,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       eat_req,
  input  logic       collision,
  input  logic [9:0] head_x,
  input  logic [8:0] head_y,
  output logic       step,
  output logic       snake_clr,
  output logic       box_valid,
  output logic [9:0] box_x,
  output logic [8:0] box_y,
  output logic [6:0] score,
  output logic       game_over
);

  localparam logic [25:0] PERIOD_INIT = 26'(STEP_INIT);
  localparam logic [25:0] PERIOD_MIN  = 26'(STEP_MIN);
  localparam logic [25:0] PERIOD_DEC  = 26'(STEP_DEC);
  localparam logic [26:0] DEC_FLOOR   = 27'(STEP_MIN) + 27'(STEP_DEC);
  localparam logic [6:0]  SCORE_SAT   = 7'(SCORE_MAX);

  state_e      state_q, state_d;
  logic        btn_q;
  logic [25:0] count_q, count_d;
  logic [25:0] period_q, period_d;
  logic [6:0]  score_q, score_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [8:0]  box_y_q, box_y_d;
  logic        box_valid_q, box_valid_d;
  logic        step_q, step_d;
  logic        snake_clr_q, snake_clr_d;

  logic [15:0] lfsr;
  logic [6:0]  cand_col;
  logic [5:0]  cand_row;
  logic [9:0]  cand_x;
  logic [8:0]  cand_y;
  logic        cand_ok;
  logic        start_edge;
  logic        step_due;
  logic        new_game;
  logic [25:0] period_next;

  snake_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  always_comb begin
    start_edge = btn_start & ~btn_q;
    cand_col   = lfsr[6:0];
    cand_row   = lfsr[14:9];
    cand_x     = {cand_col, 3'b000};
    cand_y     = {cand_row, 3'b000};
    cand_ok    = (cand_col < 7'(GRID_COLS)) && (cand_row < 6'(GRID_ROWS)) &&
                 ((cand_x != head_x) || (cand_y != head_y));
    // >= rather than == so a period that shrinks below the running count
    // still fires on the next cycle instead of waiting for a 26-bit wrap.
    step_due    = (count_q >= (period_q - 26'd1));
    period_next = ({1'b0, period_q} >= DEC_FLOOR) ? (period_q - PERIOD_DEC) : PERIOD_MIN;
    new_game    = start_edge && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      btn_q       <= 1'b0;
      count_q     <= '0;
      period_q    <= PERIOD_INIT;
      score_q     <= '0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      box_valid_q <= 1'b0;
      step_q      <= 1'b0;
      snake_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_start;
      count_q     <= count_d;
      period_q    <= period_d;
      score_q     <= score_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      box_valid_q <= box_valid_d;
      step_q      <= step_d;
      snake_clr_q <= snake_clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_PLACE;
      ST_PLACE: if (cand_ok)    state_d = ST_PLAY;
      ST_PLAY: begin
        if (collision)       state_d = ST_OVER;
        else if (eat_req)    state_d = ST_PLACE;
        else if (start_edge) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (start_edge) state_d = ST_PLAY;
      ST_OVER:  if (start_edge) state_d = ST_PLACE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    period_d    = period_q;
    score_d     = score_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    box_valid_d = box_valid_q;
    step_d      = 1'b0;
    snake_clr_d = 1'b0;

    if (new_game) begin
      snake_clr_d = 1'b1;
      score_d     = '0;
      period_d    = PERIOD_INIT;
      count_d     = '0;
      box_valid_d = 1'b0;
    end

    case (state_q)
      ST_PLACE: begin
        box_valid_d = 1'b0;
        if (cand_ok) begin
          box_x_d     = cand_x;
          box_y_d     = cand_y;
          box_valid_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // A collision ends the game on this edge; no step goes out with it.
        if (!collision) begin
          if (step_due) begin
            step_d  = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_q + 26'd1;
          end
          if (eat_req) begin
            score_d     = (score_q < SCORE_SAT) ? (score_q + 7'd1) : score_q;
            period_d    = period_next;
            box_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign step      = step_q;
  assign snake_clr = snake_clr_q;
  assign box_valid = box_valid_q;
  assign box_x     = box_x_q;
  assign box_y     = box_y_q;
  assign score     = score_q;
  assign game_over = (state_q == ST_OVER);

endmodule
